// File: rtl/cap_code_switch_sequencer.sv
// Capacitor-bank code sequencer: stability-filters lookup codes, applies them break-before-make.
// Latency: enable drops 1 clk after the stabilising valid; code loads DEAD_CYC later; enable returns SETTLE_CYC after that.
// Backpressure: none; strobes arriving while a sequence runs only update the candidate, which is evaluated back in IDLE.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   code_ser_in, code_par_in  : serial / parallel bank codes from the lookup stage
//   code_valid                : one-cycle strobe qualifying the code inputs
//   codeSer, codePar          : applied bank codes (registered)
//   enableSer, enablePar      : bank enables (registered)
//   busy                      : high while a switch sequence is in DEAD or SETTLE
//   sig_lost                  : high while measurements have stopped arriving
module cap_code_switch_sequencer #(
  parameter int unsigned STABLE_N    = 2,
  parameter int unsigned DEAD_CYC    = 20,
  parameter int unsigned SETTLE_CYC  = 40,
  parameter int unsigned TIMEOUT_CYC = 400000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] code_ser_in,
  input  logic [6:0] code_par_in,
  input  logic       code_valid,
  output logic [6:0] codeSer,
  output logic [6:0] codePar,
  output logic       enableSer,
  output logic       enablePar,
  output logic       busy,
  output logic       sig_lost
);

  localparam int unsigned MW = $clog2(STABLE_N + 1);

  localparam logic [MW-1:0]    STABLE_M    = MW'(STABLE_N);
  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_W   = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DEAD, SETTLE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [13:0]      cand_q, cand_d;
  logic [MW-1:0]    match_q, match_d;
  logic [13:0]      tgt_q;
  logic [6:0]       code_ser_q, code_par_q;
  logic             en_ser_q, en_par_q;
  logic             busy_q, sig_lost_q;

  logic [13:0]      in_pair;
  logic             timeout;
  logic             launch;

  // Stability filter, watchdog and launch decision.
  always_comb begin
    in_pair = {code_ser_in, code_par_in};
    cand_d  = cand_q;
    match_d = match_q;
    if (code_valid) begin
      if (in_pair == cand_q) begin
        if (match_q != STABLE_M) match_d = match_q + MW'(1);
      end else begin
        cand_d  = in_pair;
        match_d = MW'(1);
      end
    end

    // A strobe in the terminal watchdog cycle cancels the timeout.
    timeout = (wd_q == TIMEOUT_W) && !code_valid;
    if (code_valid)             wd_d = '0;
    else if (wd_q == TIMEOUT_W) wd_d = wd_q;
    else                        wd_d = wd_q + CNT_W'(1);

    if (timeout) match_d = '0;

    // Disabled banks (after reset or signal loss) force a full sequence even for unchanged codes.
    launch = (state_q == IDLE) && (match_q == STABLE_M) &&
             ((cand_q != {code_ser_q, code_par_q}) || !en_ser_q || !en_par_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wd_q       <= '0;
      cand_q     <= '0;
      match_q    <= '0;
      tgt_q      <= '0;
      code_ser_q <= '0;
      code_par_q <= '0;
      en_ser_q   <= 1'b0;
      en_par_q   <= 1'b0;
      busy_q     <= 1'b0;
      sig_lost_q <= 1'b1;
    end else begin
      cand_q  <= cand_d;
      match_q <= match_d;
      wd_q    <= wd_d;
      if (code_valid) sig_lost_q <= 1'b0;

      // Timeout overrides any terminal count landing in the same cycle.
      if (timeout) begin
        sig_lost_q <= 1'b1;
        en_ser_q   <= 1'b0;
        en_par_q   <= 1'b0;
        busy_q     <= 1'b0;
        cnt_q      <= '0;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (launch) begin
              tgt_q <= cand_q;
              // Only a bank whose code moves is blanked; the other stays live.
              if ((cand_q[13:7] != code_ser_q) || sig_lost_q) en_ser_q <= 1'b0;
              if ((cand_q[6:0]  != code_par_q) || sig_lost_q) en_par_q <= 1'b0;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= DEAD;
            end
          end
          DEAD: begin
            if (cnt_q == DEAD_LAST) begin
              code_ser_q <= tgt_q[13:7];
              code_par_q <= tgt_q[6:0];
              cnt_q      <= '0;
              state_q    <= SETTLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              en_ser_q <= 1'b1;
              en_par_q <= 1'b1;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
              state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign codeSer   = code_ser_q;
  assign codePar   = code_par_q;
  assign enableSer = en_ser_q;
  assign enablePar = en_par_q;
  assign busy      = busy_q;
  assign sig_lost  = sig_lost_q;

endmodule

// File: tb/tb_cap_code_switch_sequencer.sv
// Bench for cap_code_switch_sequencer with STABLE_N=2, DEAD_CYC=4, SETTLE_CYC=8, TIMEOUT_CYC=200.
// Inputs change and outputs are sampled on the falling clock edge.
// Each table row drives one cycle of inputs, idles 'gap' further cycles, then compares all outputs.
module tb_cap_code_switch_sequencer;

  logic       clk;
  logic       rst_n;
  logic [6:0] code_ser_in;
  logic [6:0] code_par_in;
  logic       code_valid;
  logic [6:0] codeSer;
  logic [6:0] codePar;
  logic       enableSer;
  logic       enablePar;
  logic       busy;
  logic       sig_lost;

  cap_code_switch_sequencer #(
    .STABLE_N   (2),
    .DEAD_CYC   (4),
    .SETTLE_CYC (8),
    .TIMEOUT_CYC(200),
    .CNT_W      (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_ser_in(code_ser_in),
    .code_par_in(code_par_in),
    .code_valid (code_valid),
    .codeSer    (codeSer),
    .codePar    (codePar),
    .enableSer  (enableSer),
    .enablePar  (enablePar),
    .busy       (busy),
    .sig_lost   (sig_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       v;
    logic [6:0] s;
    logic [6:0] p;
    int         gap;
    logic [6:0] ecs;
    logic [6:0] ecp;
    logic       ees;
    logic       eep;
    logic       eb;
    logic       esl;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input string nm, input logic v, input logic [6:0] s,
                              input logic [6:0] p, input int gap,
                              input logic [6:0] ecs, input logic [6:0] ecp,
                              input logic ees, input logic eep, input logic eb, input logic esl);
    vec_t r;
    r.nm = nm; r.v = v; r.s = s; r.p = p; r.gap = gap;
    r.ecs = ecs; r.ecp = ecp; r.ees = ees; r.eep = eep; r.eb = eb; r.esl = esl;
    vecs.push_back(r);
  endfunction

  task automatic check(input string nm, input logic [6:0] ecs, input logic [6:0] ecp,
                       input logic ees, input logic eep, input logic eb, input logic esl);
    checks++;
    if ({codeSer, codePar, enableSer, enablePar, busy, sig_lost} !==
        {ecs, ecp, ees, eep, eb, esl}) begin
      failures++;
      $display("FAIL %s: got cs=%0d cp=%0d es=%b ep=%b busy=%b sl=%b, expected cs=%0d cp=%0d es=%b ep=%b busy=%b sl=%b",
               nm, codeSer, codePar, enableSer, enablePar, busy, sig_lost,
               ecs, ecp, ees, eep, eb, esl);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    code_valid  = 1'b0;
    code_ser_in = '0;
    code_par_in = '0;
    repeat (3) @(negedge clk);
    check("in_reset", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 1: first lock to (5,9); L = edge after the stabilising valid.
    add("t1_first_valid", 1, 5, 9,  0, 0, 0, 0, 0, 0, 0);
    add("t1_wait",        0, 0, 0, 48, 0, 0, 0, 0, 0, 0);
    add("t1_stable",      1, 5, 9,  0, 0, 0, 0, 0, 0, 0);
    add("t1_launch",      0, 0, 0,  0, 0, 0, 0, 0, 1, 0);  // L
    add("t1_dead_end",    0, 0, 0,  2, 0, 0, 0, 0, 1, 0);  // L+3
    add("t1_code_load",   0, 0, 0,  0, 5, 9, 0, 0, 1, 0);  // L+4
    add("t1_settle_end",  0, 0, 0,  6, 5, 9, 0, 0, 1, 0);  // L+11
    add("t1_enable",      0, 0, 0,  0, 5, 9, 1, 1, 0, 0);  // L+12
    add("t1_hold",        0, 0, 0,  3, 5, 9, 1, 1, 0, 0);
    // 2: only the parallel bank changes.
    add("t2_first",       1, 5, 12, 29, 5, 9,  1, 1, 0, 0);
    add("t2_stable",      1, 5, 12,  0, 5, 9,  1, 1, 0, 0);
    add("t2_launch",      0, 0, 0,   0, 5, 9,  1, 0, 1, 0);
    add("t2_dead_end",    0, 0, 0,   2, 5, 9,  1, 0, 1, 0);
    add("t2_code_load",   0, 0, 0,   0, 5, 12, 1, 0, 1, 0);
    add("t2_settle_end",  0, 0, 0,   6, 5, 12, 1, 0, 1, 0);
    add("t2_enable",      0, 0, 0,   0, 5, 12, 1, 1, 0, 0);
    // 3: alternating codes never stabilise.
    add("t3_alt0",        1, 6, 12, 9, 5, 12, 1, 1, 0, 0);
    add("t3_alt1",        1, 5, 12, 9, 5, 12, 1, 1, 0, 0);
    add("t3_alt2",        1, 6, 12, 9, 5, 12, 1, 1, 0, 0);
    add("t3_alt3",        1, 5, 12, 9, 5, 12, 1, 1, 0, 0);
    // 4: new candidate arrives during DEAD; in-flight target completes, then relaunch.
    add("t4_first",       1, 7, 3, 9, 5, 12, 1, 1, 0, 0);
    add("t4_stable",      1, 7, 3, 0, 5, 12, 1, 1, 0, 0);
    add("t4_launch",      0, 0, 0, 0, 5, 12, 0, 0, 1, 0);  // L
    add("t4_new_cand1",   1, 8, 3, 0, 5, 12, 0, 0, 1, 0);  // L+1
    add("t4_new_cand2",   1, 8, 3, 0, 5, 12, 0, 0, 1, 0);  // L+2
    add("t4_dead_end",    0, 0, 0, 0, 5, 12, 0, 0, 1, 0);  // L+3
    add("t4_code_load",   0, 0, 0, 0, 7, 3,  0, 0, 1, 0);  // L+4
    add("t4_settle_end",  0, 0, 0, 6, 7, 3,  0, 0, 1, 0);  // L+11
    add("t4_enable",      0, 0, 0, 0, 7, 3,  1, 1, 0, 0);  // L+12
    add("t4_relaunch",    0, 0, 0, 0, 7, 3,  0, 1, 1, 0);  // L+13
    add("t4_reload",      0, 0, 0, 3, 8, 3,  0, 1, 1, 0);  // L+17
    add("t4_reenable",    0, 0, 0, 7, 8, 3,  1, 1, 0, 0);  // L+25
    // 5: signal loss. Last valid V = L+2 above, so we are at V+23.
    add("t5_wd_at_limit", 0, 0, 0, 176, 8, 3, 1, 1, 0, 0); // V+200
    add("t5_timeout",     0, 0, 0,   0, 8, 3, 0, 0, 0, 1); // V+201
    add("t5_resume1",     1, 8, 3,   9, 8, 3, 0, 0, 0, 0);
    add("t5_resume2",     1, 8, 3,   0, 8, 3, 0, 0, 0, 0); // V2
    add("t5_launch",      0, 0, 0,   0, 8, 3, 0, 0, 1, 0);
    add("t5_settle_end",  0, 0, 0,  10, 8, 3, 0, 0, 1, 0);
    add("t5_reenable",    0, 0, 0,   0, 8, 3, 1, 1, 0, 0); // V2+13
    add("t5_wd_edge",     0, 0, 0, 186, 8, 3, 1, 1, 0, 0); // V2+200
    add("t5_valid_at_to", 1, 8, 3,   0, 8, 3, 1, 1, 0, 0); // valid cancels timeout
    // 6: launch toward (1,2) and stop inside SETTLE.
    add("t6_first",       1, 1, 2, 9, 8, 3, 1, 1, 0, 0);
    add("t6_stable",      1, 1, 2, 0, 8, 3, 1, 1, 0, 0);
    add("t6_launch",      0, 0, 0, 0, 8, 3, 0, 0, 1, 0);
    add("t6_in_settle",   0, 0, 0, 5, 1, 2, 0, 0, 1, 0);   // L+6

    for (int i = 0; i < vecs.size(); i++) begin
      code_valid  = vecs[i].v;
      code_ser_in = vecs[i].s;
      code_par_in = vecs[i].p;
      @(negedge clk);
      code_valid = 1'b0;
      repeat (vecs[i].gap) @(negedge clk);
      check(vecs[i].nm, vecs[i].ecs, vecs[i].ecp, vecs[i].ees, vecs[i].eep,
            vecs[i].eb, vecs[i].esl);
    end

    // Asynchronous reset in SETTLE: outputs clear without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t6_after_release", 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cap_code_switch_sequencer.md
Name: cap_code_switch_sequencer

Overview:
- Downstream of the frequency-measurement/code-lookup stage in the QCM master controller.
- Consumes per-measurement serial/parallel capacitor codes with a valid strobe and filters them for stability.
- Drives the capacitor-bank codes and enables with a break-before-make sequence: disable, dead time, load code, settle, re-enable.
- Blanks both banks when measurements stop arriving (signal lost).

Parameters:
- STABLE_N, 2, consecutive identical code pairs required before a switch is launched (>=1)
- DEAD_CYC, 20, clk cycles the changing bank's enable is low before its code changes (>=1)
- SETTLE_CYC, 40, clk cycles after the code change before the enable reasserts (>=1)
- TIMEOUT_CYC, 400000, clk cycles without code_valid before sig_lost asserts
- CNT_W, 20, width of the dead/settle/timeout counters; must hold TIMEOUT_CYC

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- code_ser_in  in  7  serial-bank code from the upstream lookup
- code_par_in  in  7  parallel-bank code from the upstream lookup
- code_valid  in  1  one-cycle strobe; the code inputs are valid this cycle
- codeSer  out  7  applied serial-bank code (registered)
- codePar  out  7  applied parallel-bank code (registered)
- enableSer  out  1  serial-bank enable (registered)
- enablePar  out  1  parallel-bank enable (registered)
- busy  out  1  high while in DEAD or SETTLE
- sig_lost  out  1  high while measurements have timed out

Behaviour:
- Reset (async assert, sync release): codeSer=codePar=0, enableSer=enablePar=0, busy=0, sig_lost=1, FSM=IDLE, all counters 0, candidate=0, match_cnt=0.
- Stability filter, active in every state:
  - When code_valid is high and {code_ser_in,code_par_in} equals the candidate: match_cnt increments, saturating at STABLE_N.
  - Otherwise, on code_valid: candidate<=inputs, match_cnt<=1.
- Launch condition, checked in IDLE only: match_cnt==STABLE_N and (candidate differs from {codeSer,codePar}, or either enable is 0).
- FSM states: IDLE, DEAD, SETTLE.
- IDLE -> DEAD on the edge after the launch condition is true:
  - Latch the target from the candidate.
  - Clear enableSer if the serial target differs or sig_lost was set; same rule for enablePar.
  - An unchanged bank keeps its enable high.
  - busy<=1, counter<=0.
- DEAD: counter increments. At counter==DEAD_CYC-1:
  - codeSer/codePar<=target; FSM->SETTLE; counter<=0.
  - The code change occurs exactly DEAD_CYC cycles after the enable drop.
- SETTLE: counter increments. At counter==SETTLE_CYC-1:
  - enableSer<=1, enablePar<=1, busy<=0, FSM->IDLE.
- Latency from the valid that completes stability:
  - enable falls 1 cycle later.
  - code changes DEAD_CYC+1 cycles later.
  - enable rises DEAD_CYC+SETTLE_CYC+1 cycles later.
- A candidate that changes during DEAD/SETTLE does not abort the sequence. The in-flight target completes; the new candidate is evaluated in IDLE afterwards. Earliest relaunch is the cycle after returning to IDLE.
- Watchdog:
  - Counts clk cycles since the last code_valid; cleared on code_valid.
  - On reaching TIMEOUT_CYC, on the next edge: sig_lost<=1, enableSer=enablePar<=0, busy<=0, FSM->IDLE, match_cnt<=0.
  - Codes are held at their last values. The watchdog saturates.
- sig_lost clears on the first code_valid.
- Recovery: the next stable candidate launches a full sequence even if it equals the applied codes, because the enables are 0. Both banks go through DEAD/SETTLE.
- Timeout occurring in the same cycle as a DEAD/SETTLE terminal count: timeout wins.
- code_valid in the same cycle as a timeout: the timeout is not asserted, because the watchdog clears.
- rst_n asserted mid-sequence: immediate return to reset values.
- The two enables never rise except at the SETTLE terminal count.

Test Plan (STABLE_N=2, DEAD_CYC=4, SETTLE_CYC=8, TIMEOUT_CYC=200, valid every 50 cycles unless noted):
1. Reset release, then code pair (5,9) valid twice -> enables stay 0 until the sequence runs; codeSer=5, codePar=9 four cycles after launch; both enables=1 twelve cycles after launch; sig_lost=0 from the first valid.
2. From (5,9) steady, present (5,12) twice -> enableSer stays 1 throughout; enablePar low for exactly 12 cycles; codePar changes 9->12 at cycle 4 of that window; codeSer never changes.
3. Alternate (5,12)/(6,12) on every valid -> match_cnt never reaches 2; no sequence; outputs unchanged; busy stays 0.
4. Launch (7,3) and, during DEAD, deliver (8,3) twice -> (7,3) completes; a second sequence to (8,3) starts the cycle after IDLE re-entry.
5. Stop code_valid for 200 cycles -> sig_lost=1 and both enables=0 on the next edge; codes held. Resume with the same pair twice -> full DEAD/SETTLE sequence; both enables return to 1.
6. Assert rst_n low during SETTLE -> all outputs go to reset values immediately (asynchronously); no enable glitch high after release.
